db_mcu_bridge: RTL and testbench

- Executes debugger commands against the MCU core. Sits directly downstream of mcu_controller, which decodes UART frames into one-cycle command strobes.
- Consumes pause/resume/reset/register/memory strobes plus addr/d_in.
- Drives the MCU halt, reset, register-file and memory ports.
- Returns d_rd, mcu_busy and error to mcu_controller.

---
 rtl/db_mcu_bridge.sv | 162 ++++++++++++++++
 tb/tb_db_mcu_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db_mcu_bridge.sv
// Debug command executor between mcu_controller and the MCU core: halt/resume/reset,
// register-file and memory access. Optional DB_PC_READ_EN maps reg_rd index 32 to the PC.
module db_mcu_bridge #(
  parameter int HALT_TIMEOUT = 255,
  parameter int MEM_TIMEOUT  = 255,
  parameter int RST_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        pause,
  input  logic        resume,
  input  logic        reset,
  input  logic        reg_rd,
  input  logic        reg_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_rw_byte,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_rd,
  output logic        mcu_busy,
  output logic        error,
  output logic        mcu_halt_req,
  input  logic        mcu_halted,
  output logic        mcu_rst,
  input  logic [31:0] pc,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wd,
  output logic        rf_we,
  input  logic [31:0] rf_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_size,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HALT_WAIT = 3'd1;
  localparam logic [2:0] REG_ACC   = 3'd2;
  localparam logic [2:0] MEM_REQ   = 3'd3;
  localparam logic [2:0] RST_PULSE = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam int CW = 16;
  localparam logic [CW-1:0] HALT_LAST = CW'(HALT_TIMEOUT - 1);
  localparam logic [CW-1:0] MEM_LAST  = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   cmd_addr, cmd_data;
  logic          cmd_wr, cmd_byte, cmd_pc;
  logic          halt_req;
  logic          pc_sel, reg_ok, mem_ok;
  logic [31:0]   pc_val;

`ifdef DB_PC_READ_EN
  // reg_rd outranks reg_wr, so only a read may select the PC slot
  assign pc_sel = reg_rd && (addr == 32'd32);
  assign pc_val = pc;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign pc_sel    = 1'b0;
  assign pc_val    = '0;
`endif

  assign reg_ok  = mcu_halted && ((addr < 32'd32) || pc_sel);
  assign mem_ok  = mcu_halted && (mem_rw_byte || (addr[1:0] == 2'b00));
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  assign mcu_busy     = (state != IDLE);
  assign mcu_halt_req = halt_req;
  assign mcu_rst      = (state == RST_PULSE);
  assign rf_addr      = cmd_addr[4:0];
  assign rf_wd        = cmd_data;
  assign rf_we        = (state == REG_ACC) && cmd_wr && (cmd_addr[4:0] != 5'd0);
  assign mem_addr     = cmd_addr;
  assign mem_wd       = cmd_byte ? {4{cmd_data[7:0]}} : cmd_data;
  assign mem_size     = (state == MEM_REQ && !cmd_byte) ? 2'd2 : 2'd0;
  assign mem_re       = (state == MEM_REQ) && !cmd_wr;
  assign mem_we       = (state == MEM_REQ) && cmd_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_wr   <= 1'b0;
      cmd_byte <= 1'b0;
      cmd_pc   <= 1'b0;
      halt_req <= 1'b0;
      d_rd     <= '0;
      error    <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          cnt <= '0;
          if (pause) begin
            halt_req <= 1'b1;
            state    <= HALT_WAIT;
          end else if (resume) begin
            halt_req <= 1'b0;
            state    <= DONE;
          end else if (reset) begin
            state <= RST_PULSE;
          end else if (reg_rd || reg_wr) begin
            cmd_addr <= addr;
            cmd_data <= d_in;
            cmd_wr   <= !reg_rd;
            cmd_pc   <= pc_sel;
            if (reg_ok) state <= REG_ACC;
            else begin state <= DONE; error <= 1'b1; end
          end else if (mem_rd || mem_wr) begin
            cmd_addr <= addr;
            cmd_data <= d_in;
            cmd_wr   <= !mem_rd;
            cmd_byte <= mem_rw_byte;
            if (mem_ok) state <= MEM_REQ;
            else begin state <= DONE; error <= 1'b1; end
          end
        end
        HALT_WAIT: begin
          if (mcu_halted) state <= DONE;
          else if (cnt == HALT_LAST) begin
            halt_req <= 1'b0;
            error    <= 1'b1;
            state    <= DONE;
          end else cnt <= cnt_inc;
        end
        REG_ACC: begin
          if (!cmd_wr)
            d_rd <= cmd_pc ? pc_val : (cmd_addr[4:0] == 5'd0) ? '0 : rf_rd;
          state <= DONE;
        end
        MEM_REQ: begin
          // an ack arriving on the final timeout cycle still wins
          if (mem_ack) begin
            if (!cmd_wr) d_rd <= cmd_byte ? {24'd0, mem_rdata[7:0]} : mem_rdata;
            state <= DONE;
          end else if (cnt == MEM_LAST) begin
            error <= 1'b1;
            state <= DONE;
          end else cnt <= cnt_inc;
        end
        RST_PULSE: begin
          if (cnt == RST_LAST) state <= DONE;
          else cnt <= cnt_inc;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (valid && state != IDLE) error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_db_mcu_bridge.sv
// Directed bench for db_mcu_bridge: register, memory, halt, reset and timeout paths.
module tb_db_mcu_bridge;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 0, pause = 0, resume = 0, rst_cmd = 0;
  logic        reg_rd = 0, reg_wr = 0, mem_rd = 0, mem_wr = 0, mem_rw_byte = 0;
  logic [31:0] addr = 0, d_in = 0, d_rd, pc = 32'h0000_0ABC;
  logic        mcu_busy, error, mcu_halt_req, mcu_halted = 0, mcu_rst;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd, rf_rd, mem_addr, mem_wd, mem_rdata = 0;
  logic        rf_we, mem_re, mem_we, mem_ack = 0;
  logic [1:0]  mem_size;
  logic [31:0] rf [32];

  int n_chk = 0, n_err = 0;

  localparam logic [6:0] C_PAUSE  = 7'b1000000;
  localparam logic [6:0] C_RESUME = 7'b0100000;
  localparam logic [6:0] C_RESET  = 7'b0010000;
  localparam logic [6:0] C_RRD    = 7'b0001000;
  localparam logic [6:0] C_RWR    = 7'b0000100;
  localparam logic [6:0] C_MRD    = 7'b0000010;
  localparam logic [6:0] C_MWR    = 7'b0000001;

  always #5 clk = ~clk;

  db_mcu_bridge dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .pause(pause), .resume(resume),
    .reset(rst_cmd), .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rw_byte(mem_rw_byte), .addr(addr), .d_in(d_in), .d_rd(d_rd),
    .mcu_busy(mcu_busy), .error(error), .mcu_halt_req(mcu_halt_req),
    .mcu_halted(mcu_halted), .mcu_rst(mcu_rst), .pc(pc), .rf_addr(rf_addr),
    .rf_wd(rf_wd), .rf_we(rf_we), .rf_rd(rf_rd), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_size(mem_size), .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // external register file: entry i powers up as 0xDEAD_00ii
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 32; i++) rf[i] <= 32'hDEAD_0000 | 32'(i);
    else if (rf_we) rf[rf_addr] <= rf_wd;
  end
  assign rf_rd = rf[rf_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // called at a negedge; valid is seen by the next posedge (cycle N)
  task automatic cmd(input logic [6:0] sel, input logic [31:0] a, input logic [31:0] d,
                     input logic b);
    {pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr} = sel;
    addr = a; d_in = d; mem_rw_byte = b; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    {pause, resume, rst_cmd, reg_rd, reg_wr, mem_rd, mem_wr} = '0;
  endtask

  initial begin
    int hit, cnt;
    repeat (2) nx();
    chk("rst_busy", mcu_busy, 0);
    chk("rst_drd", d_rd, 0);
    chk("rst_err", error, 0);
    chk("rst_hreq", mcu_halt_req, 0);
    chk("rst_outs", {mcu_rst, mem_re, mem_we, rf_we, mem_size}, 0);
    rst_n = 1'b1;
    nx();

    // register write / read, halted
    mcu_halted = 1'b1;
    cmd(C_RWR, 32'd5, 32'hA5A5_0001, 0); nx();
    chk("wr5_we", rf_we, 1);
    chk("wr5_addr", rf_addr, 5);
    chk("wr5_wd", rf_wd, 32'hA5A5_0001);
    chk("wr5_busy1", mcu_busy, 1);
    nx();
    chk("wr5_busy2", {mcu_busy, rf_we, error}, 3'b100);
    nx();
    chk("wr5_idle", mcu_busy, 0);

    cmd(C_RRD, 32'd5, 0, 0); nx();
    chk("rd5_busy1", mcu_busy, 1);
    nx();
    chk("rd5_data", d_rd, 32'hA5A5_0001);
    chk("rd5_busy2", mcu_busy, 1);
    nx();
    chk("rd5_idle", mcu_busy, 0);

    cmd(C_RWR, 32'd0, 32'hFFFF_FFFF, 0); nx();
    chk("wr0_we", rf_we, 0);
    nx(); nx();
    cmd(C_RRD, 32'd0, 0, 0); nx(); nx();
    chk("rd0_data", d_rd, 0);
    nx();
    cmd(C_RRD, 32'd7, 0, 0); nx(); nx();
    chk("rd7_data", d_rd, 32'hDEAD_0007);
    nx();

    mcu_halted = 1'b0;
    cmd(C_RRD, 32'd3, 0, 0); nx();
    chk("rd_nohalt_err", error, 1);
    chk("rd_nohalt_drd", d_rd, 32'hDEAD_0007);
    nx();
    chk("rd_nohalt_err1", {error, mcu_busy}, 0);

    mcu_halted = 1'b1;
    cmd(C_RRD, 32'd33, 0, 0); nx();
    chk("rd33_err", error, 1);
    nx();
    cmd(C_RRD, 32'd32, 0, 0); nx();
`ifdef DB_PC_READ_EN
    chk("rd32_noerr", error, 0);
    nx();
    chk("rd32_pc", d_rd, 32'h0000_0ABC);
`else
    chk("rd32_err", error, 1);
    nx();
    chk("rd32_drd", d_rd, 32'hDEAD_0007);
`endif
    nx();

    // empty strobe is ignored silently
    cmd(7'b0, 0, 0, 0); nx();
    chk("nosel", {mcu_busy, error}, 0);

    // pause + mem_wr together: pause wins, already halted exits at once
    cmd(C_PAUSE | C_MWR, 32'h10, 0, 0); nx();
    chk("prio_hreq", {mcu_halt_req, mem_we}, 2'b10);
    nx();
    chk("pause_fast_done", {mcu_busy, error}, 2'b10);
    nx();
    chk("pause_fast_idle", mcu_busy, 0);

    // reset pulse, with a collision strobe during it
    cmd(C_RESET, 0, 0, 0);
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      nx();
      if (mcu_rst) cnt++;
      if (i == 2) begin valid = 1'b1; reg_rd = 1'b1; end
      if (i == 3) begin chk("rst_busy_err", error, 1); valid = 1'b0; reg_rd = 1'b0; end
      if (i == 5) chk("rst_done_busy", mcu_busy, 1);
      if (i == 6) chk("rst_back_idle", mcu_busy, 0);
    end
    chk("rst_len", cnt, 4);
    chk("rst_hreq_kept", mcu_halt_req, 1);

    // resume while not halted: no error
    mcu_halted = 1'b0;
    cmd(C_RESUME, 0, 0, 0); nx();
    chk("resume", {mcu_halt_req, error, mcu_busy}, 3'b001);
    nx();

    // pause, core halts 7 cycles later
    cmd(C_PAUSE, 0, 0, 0);
    cnt = 0;
    for (int i = 1; i <= 7; i++) begin
      nx();
      if (mcu_halt_req) cnt++;
    end
    chk("pause_hreq_held", cnt, 7);
    mcu_halted = 1'b1;
    nx();
    chk("pause_done", {mcu_busy, error}, 2'b10);
    nx();
    chk("pause_idle", {mcu_busy, mcu_halt_req}, 2'b01);

    // pause timeout
    mcu_halted = 1'b0;
    cmd(C_PAUSE, 0, 0, 0);
    hit = 0;
    for (int k = 1; k <= 400; k++) begin
      nx();
      if (error) begin hit = k; break; end
    end
    chk("halt_to_cycle", hit, 256);
    chk("halt_to_hreq", mcu_halt_req, 0);
    nx();

    // memory: byte read with delayed ack
    mcu_halted = 1'b1;
    cmd(C_MRD, 32'h103, 0, 1); nx();
    chk("mrd_b_req", {mem_re, mem_we, mem_size}, 4'b1000);
    chk("mrd_b_addr", mem_addr, 32'h103);
    nx(); nx();
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    nx();
    mem_ack = 1'b0;
    chk("mrd_b_data", d_rd, 32'h0000_0044);
    chk("mrd_b_done", {mem_re, error, mcu_busy}, 3'b001);
    nx();

    // byte write replicates low byte
    cmd(C_MWR, 32'h201, 32'h0000_00C7, 1); nx();
    chk("mwr_b_we", mem_we, 1);
    chk("mwr_b_wd", mem_wd, 32'hC7C7_C7C7);
    mem_ack = 1'b1;
    nx();
    mem_ack = 1'b0;
    chk("mwr_b_done", {mem_we, error}, 0);
    nx();

    // misaligned word write
    cmd(C_MWR, 32'h102, 32'h1, 0); nx();
    chk("mwr_misalign", {error, mem_we}, 2'b10);
    nx();

    // word read with no ack: timeout
    cmd(C_MRD, 32'h100, 0, 0); nx();
    chk("mrd_w_size", mem_size, 2);
    hit = 0;
    for (int k = 2; k <= 400; k++) begin
      nx();
      if (error) begin hit = k; break; end
    end
    chk("mem_to_cycle", hit, 256);
    chk("mem_to_re", mem_re, 0);
    chk("mem_to_drd", d_rd, 32'h0000_0044);
    nx();

    // ack on the last timeout cycle succeeds
    cmd(C_MRD, 32'h104, 0, 0);
    repeat (255) nx();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    nx();
    mem_ack = 1'b0;
    chk("mem_edge_err", error, 0);
    chk("mem_edge_data", d_rd, 32'hCAFE_F00D);
    nx();

    // async reset in the middle of a memory request
    cmd(C_MRD, 32'h200, 0, 0); nx();
    chk("mid_re", mem_re, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", {mem_re, mcu_busy, mcu_halt_req}, 0);
    chk("mid_rst_drd", d_rd, 0);
    nx();
    rst_n = 1'b1;
    nx();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
